// File: rtl/deci_up_counter_if.sv
// deci_up_counter_if: control and status bundle of the two-digit BCD
// up-counter. The master drives enable/load, the counter (slave) drives
// the digits and the flags back.
interface deci_up_counter_if;
  logic       en;        // count enable
  logic       load;      // synchronous load request
  logic [7:0] load_val;  // BCD load value, [7:4] tens, [3:0] ones
  logic [3:0] cnt_ones;  // ones digit, 0..9
  logic [3:0] cnt_tens;  // tens digit, 0..9
  logic       tc;        // terminal count (count == LIMIT and en)
  logic       load_err;  // one-cycle pulse after a rejected load

  modport master (
    output en, load, load_val,
    input  cnt_ones, cnt_tens, tc, load_err
  );

  modport slave (
    input  en, load, load_val,
    output cnt_ones, cnt_tens, tc, load_err
  );
endinterface

// File: rtl/deci_up_counter.sv
// deci_up_counter: two-digit BCD up-counter 00..LIMIT with count enable,
// synchronous parallel load with range checking, a combinational
// terminal-count flag and a registered load-error pulse.
//
// Build option: define DECI_UP_CNT_SATURATE_EN to make the counter hold at
// LIMIT instead of wrapping to 00. Load behaviour is the same either way.
//
// Reset rst is asynchronous and active-low.
module deci_up_counter #(
  parameter int LIMIT = 99  // terminal count as a decimal integer, 1..99
) (
  input  logic              clk,
  input  logic              rst,
  deci_up_counter_if.slave  bus
);

  localparam logic [3:0] LIMIT_TENS = 4'(LIMIT / 10);
  localparam logic [3:0] LIMIT_ONES = 4'(LIMIT % 10);

  // Registered state: the count itself is the whole state machine.
  logic [3:0] ones_reg, ones_next;
  logic [3:0] tens_reg, tens_next;
  logic       load_err_reg, load_err_next;

  // Digit views of the load value and of the current count, index 0 = ones.
  logic [3:0] load_digit [2];
  logic [3:0] cnt_digit  [2];
  logic [1:0] load_digit_ok;
  logic [1:0] cnt_digit_ok;

  assign cnt_digit[0] = ones_reg;
  assign cnt_digit[1] = tens_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_digit
      assign load_digit[gi]    = bus.load_val[gi*4 +: 4];
      assign load_digit_ok[gi] = (load_digit[gi] <= 4'd9);
      assign cnt_digit_ok[gi]  = (cnt_digit[gi] <= 4'd9);
    end
  endgenerate

  // Range compare done digit-wise in BCD; only meaningful once both digits
  // are known to be decimal, which the validity terms below guarantee.
  logic load_in_range;
  logic load_valid;
  logic cnt_in_range;
  logic cnt_legal;
  logic at_limit;
  logic ones_at_nine;

  assign load_in_range = (load_digit[1] < LIMIT_TENS) ||
                         ((load_digit[1] == LIMIT_TENS) && (load_digit[0] <= LIMIT_ONES));
  assign load_valid    = (&load_digit_ok) && load_in_range;

  assign cnt_in_range  = (tens_reg < LIMIT_TENS) ||
                         ((tens_reg == LIMIT_TENS) && (ones_reg <= LIMIT_ONES));
  assign cnt_legal     = (&cnt_digit_ok) && cnt_in_range;

  assign at_limit      = (tens_reg == LIMIT_TENS) && (ones_reg == LIMIT_ONES);
  assign ones_at_nine  = (ones_reg == 4'd9);

  // Next-state: load beats enable beats hold; illegal counts recover to 00.
  always_comb begin
    ones_next     = ones_reg;
    tens_next     = tens_reg;
    load_err_next = 1'b0;
    if (bus.load) begin
      if (load_valid) begin
        ones_next = load_digit[0];
        tens_next = load_digit[1];
      end else begin
        load_err_next = 1'b1;
      end
    end else if (bus.en) begin
      if (!cnt_legal) begin
        ones_next = 4'd0;
        tens_next = 4'd0;
      end else if (at_limit) begin
`ifdef DECI_UP_CNT_SATURATE_EN
        ones_next = ones_reg;
        tens_next = tens_reg;
`else
        ones_next = 4'd0;
        tens_next = 4'd0;
`endif
      end else if (ones_at_nine) begin
        ones_next = 4'd0;
        tens_next = tens_reg + 4'd1;
      end else begin
        ones_next = ones_reg + 4'd1;
      end
    end
  end

  // State register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ones_reg     <= 4'd0;
      tens_reg     <= 4'd0;
      load_err_reg <= 1'b0;
    end else begin
      ones_reg     <= ones_next;
      tens_reg     <= tens_next;
      load_err_reg <= load_err_next;
    end
  end

  // tc depends only on the registered count and en, so it can drive the
  // en of a following stage that must advance on the wrap edge.
  assign bus.cnt_ones = ones_reg;
  assign bus.cnt_tens = tens_reg;
  assign bus.load_err = load_err_reg;
  assign bus.tc       = at_limit & bus.en;

endmodule

// File: tb/tb_deci_up_counter.sv
// tb_deci_up_counter: drives a LIMIT=99 and a LIMIT=23 counter and compares
// them against a decimal-integer reference model.
module tb_deci_up_counter;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  int   n_txn;

  // Reference model state: plain decimal count and error flag per DUT.
  int   m99_val, m23_val;
  bit   m99_err, m23_err;

  deci_up_counter_if a ();
  deci_up_counter_if b ();

  deci_up_counter #(.LIMIT(99)) dut99 (.clk(clk), .rst(rst), .bus(a));
  deci_up_counter #(.LIMIT(23)) dut23 (.clk(clk), .rst(rst), .bus(b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic bit load_ok(input int limit, input logic [7:0] lv);
    int hi;
    int lo;
    hi = int'(lv[7:4]);
    lo = int'(lv[3:0]);
    return (hi <= 9) && (lo <= 9) && (hi * 10 + lo <= limit);
  endfunction

  function automatic int model_val(input int limit, input int val, input logic en,
                                   input logic load, input logic [7:0] lv);
    if (load) begin
      if (load_ok(limit, lv)) return int'(lv[7:4]) * 10 + int'(lv[3:0]);
      return val;
    end
    if (en) begin
`ifdef DECI_UP_CNT_SATURATE_EN
      if (val == limit) return limit;
`else
      if (val == limit) return 0;
`endif
      return val + 1;
    end
    return val;
  endfunction

  function automatic bit model_err(input int limit, input logic load, input logic [7:0] lv);
    return load && !load_ok(limit, lv);
  endfunction

  // Advance one clock with whatever inputs are on both buses.
  task automatic tick();
    m99_err = model_err(99, a.load, a.load_val);
    m99_val = model_val(99, m99_val, a.en, a.load, a.load_val);
    m23_err = model_err(23, b.load, b.load_val);
    m23_val = model_val(23, m23_val, b.en, b.load, b.load_val);
    @(posedge clk);
    #1;
    n_txn++;
    $display("txn %0d: a en=%b ld=%b lv=%h -> %h%h err=%b | b en=%b ld=%b lv=%h -> %h%h err=%b",
             n_txn, a.en, a.load, a.load_val, a.cnt_tens, a.cnt_ones, a.load_err,
             b.en, b.load, b.load_val, b.cnt_tens, b.cnt_ones, b.load_err);
  endtask

  task automatic idle_inputs();
    a.en = 1'b0; a.load = 1'b0; a.load_val = 8'h00;
    b.en = 1'b0; b.load = 1'b0; b.load_val = 8'h00;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #2;
    n_total++;
    if ({a.cnt_tens, a.cnt_ones, a.load_err, a.tc} !== 10'h000)
      $display("FAIL reset_a got=%h%h err=%b tc=%b exp=00 err=0 tc=0", a.cnt_tens, a.cnt_ones, a.load_err, a.tc);
    else n_pass++;
    n_total++;
    if ({b.cnt_tens, b.cnt_ones, b.load_err} !== 9'h000)
      $display("FAIL reset_b got=%h%h err=%b exp=00 err=0", b.cnt_tens, b.cnt_ones, b.load_err);
    else n_pass++;
    m99_val = 0; m99_err = 0; m23_val = 0; m23_err = 0;
    @(negedge clk);
    rst = 1'b1;
    // Count up to 47, then pull reset asynchronously mid-cycle.
    a.en = 1'b1;
    for (int i = 0; i < 47; i++) tick();
    n_total++;
    if ({a.cnt_tens, a.cnt_ones} !== 8'h47)
      $display("FAIL count_to_47 got=%h%h exp=47", a.cnt_tens, a.cnt_ones);
    else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_total++;
    if ({a.cnt_tens, a.cnt_ones, a.load_err} !== 9'h000)
      $display("FAIL async_reset got=%h%h err=%b exp=00 err=0", a.cnt_tens, a.cnt_ones, a.load_err);
    else n_pass++;
    n_total++;
    if (a.tc !== 1'b0) $display("FAIL tc_in_reset got=%b exp=0", a.tc);
    else n_pass++;
    m99_val = 0; m99_err = 0; m23_val = 0; m23_err = 0;
    @(negedge clk);
    rst = 1'b1;
    // 100 enabled edges: 01..99 then back to 00; tc only while showing 99.
    for (int i = 0; i < 100; i++) begin
      #1;
      n_total++;
      if (a.tc !== ((m99_val == 99) ? 1'b1 : 1'b0))
        $display("FAIL tc_seq count=%0d got=%b exp=%b", m99_val, a.tc, (m99_val == 99));
      else n_pass++;
      tick();
      n_total++;
      if ({a.cnt_tens, a.cnt_ones} !== to_bcd(m99_val))
        $display("FAIL count_seq got=%h%h exp=%h", a.cnt_tens, a.cnt_ones, to_bcd(m99_val));
      else n_pass++;
    end
    n_total++;
    if ({a.cnt_tens, a.cnt_ones} !== 8'h00)
      $display("FAIL wrap_99 got=%h%h exp=00", a.cnt_tens, a.cnt_ones);
    else n_pass++;
  endtask

  task automatic test_valid_load();
    idle_inputs();
    a.load = 1'b1; a.en = 1'b1; a.load_val = 8'h57;
    tick();
    n_total++;
    if ({a.cnt_tens, a.cnt_ones, a.load_err} !== {8'h57, 1'b0})
      $display("FAIL load_57 got=%h%h err=%b exp=57 err=0", a.cnt_tens, a.cnt_ones, a.load_err);
    else n_pass++;
    a.load = 1'b0;
    tick();
    n_total++;
    if ({a.cnt_tens, a.cnt_ones, a.load_err} !== {8'h58, 1'b0})
      $display("FAIL after_load_58 got=%h%h err=%b exp=58 err=0", a.cnt_tens, a.cnt_ones, a.load_err);
    else n_pass++;
  endtask

  task automatic test_invalid_load();
    logic [7:0] bad_vals [2];
    bad_vals[0] = 8'h5A;
    bad_vals[1] = 8'hA3;
    idle_inputs();
    a.load = 1'b1; a.load_val = 8'h12;
    tick();
    for (int i = 0; i < 2; i++) begin
      a.load = 1'b1; a.en = 1'b1; a.load_val = bad_vals[i];
      tick();
      n_total++;
      if ({a.cnt_tens, a.cnt_ones, a.load_err} !== {8'h12, 1'b1})
        $display("FAIL bad_load_%h got=%h%h err=%b exp=12 err=1", bad_vals[i], a.cnt_tens, a.cnt_ones, a.load_err);
      else n_pass++;
      a.load = 1'b0; a.en = 1'b0;
      tick();
      n_total++;
      if ({a.cnt_tens, a.cnt_ones, a.load_err} !== {8'h12, 1'b0})
        $display("FAIL err_clear_%h got=%h%h err=%b exp=12 err=0", bad_vals[i], a.cnt_tens, a.cnt_ones, a.load_err);
      else n_pass++;
    end
  endtask

  task automatic test_reduced_limit();
    logic [7:0] exp_seq [3];
    exp_seq[0] = 8'h22; exp_seq[1] = 8'h23; exp_seq[2] = 8'h00;
    idle_inputs();
    b.load = 1'b1; b.load_val = 8'h21;
    tick();
    b.load = 1'b0; b.en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (b.tc !== ((i == 2) ? 1'b1 : 1'b0))
        $display("FAIL tc23_step%0d got=%b exp=%b", i, b.tc, (i == 2));
      else n_pass++;
      tick();
      n_total++;
      if ({b.cnt_tens, b.cnt_ones} !== exp_seq[i])
        $display("FAIL lim23_step%0d got=%h%h exp=%h", i, b.cnt_tens, b.cnt_ones, exp_seq[i]);
      else n_pass++;
    end
    b.en = 1'b0; b.load = 1'b1; b.load_val = 8'h24;
    tick();
    n_total++;
    if ({b.cnt_tens, b.cnt_ones, b.load_err} !== {8'h00, 1'b1})
      $display("FAIL load24_reject got=%h%h err=%b exp=00 err=1", b.cnt_tens, b.cnt_ones, b.load_err);
    else n_pass++;
    b.load_val = 8'h23;
    tick();
    n_total++;
    if ({b.cnt_tens, b.cnt_ones, b.load_err} !== {8'h23, 1'b0})
      $display("FAIL load23_accept got=%h%h err=%b exp=23 err=0", b.cnt_tens, b.cnt_ones, b.load_err);
    else n_pass++;
  endtask

  task automatic test_hold();
    idle_inputs();
    a.load = 1'b1; a.load_val = 8'h09;
    tick();
    a.load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_total++;
      if ({a.cnt_tens, a.cnt_ones, a.tc} !== {8'h09, 1'b0})
        $display("FAIL hold_09 cyc=%0d got=%h%h tc=%b exp=09 tc=0", i, a.cnt_tens, a.cnt_ones, a.tc);
      else n_pass++;
    end
    a.en = 1'b1;
    tick();
    n_total++;
    if ({a.cnt_tens, a.cnt_ones} !== 8'h10)
      $display("FAIL hold_release got=%h%h exp=10", a.cnt_tens, a.cnt_ones);
    else n_pass++;
  endtask

  task automatic test_terminal();
    idle_inputs();
    a.load = 1'b1; a.en = 1'b1; a.load_val = 8'h98;
    tick();
    a.load = 1'b0;
    tick();
    n_total++;
    if ({a.cnt_tens, a.cnt_ones} !== 8'h99)
      $display("FAIL reach_99 got=%h%h exp=99", a.cnt_tens, a.cnt_ones);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_total++;
      if (a.tc !== ((m99_val == 99) ? 1'b1 : 1'b0))
        $display("FAIL tc_term cyc=%0d got=%b exp=%b", i, a.tc, (m99_val == 99));
      else n_pass++;
      tick();
      n_total++;
      if ({a.cnt_tens, a.cnt_ones} !== to_bcd(m99_val))
        $display("FAIL term_step%0d got=%h%h exp=%h", i, a.cnt_tens, a.cnt_ones, to_bcd(m99_val));
      else n_pass++;
    end
    a.load = 1'b1; a.load_val = 8'h00;
    tick();
    n_total++;
    if ({a.cnt_tens, a.cnt_ones, a.load_err} !== 9'h000)
      $display("FAIL term_load00 got=%h%h err=%b exp=00 err=0", a.cnt_tens, a.cnt_ones, a.load_err);
    else n_pass++;
  endtask

  task automatic test_random();
    idle_inputs();
    for (int i = 0; i < 300; i++) begin
      a.en       = ($urandom_range(0, 3) != 0);
      a.load     = ($urandom_range(0, 7) == 0);
      a.load_val = ($urandom_range(0, 1) == 0) ? 8'($urandom) : to_bcd(int'($urandom_range(0, 99)));
      b.en       = ($urandom_range(0, 3) != 0);
      b.load     = ($urandom_range(0, 7) == 0);
      b.load_val = ($urandom_range(0, 1) == 0) ? 8'($urandom) : to_bcd(int'($urandom_range(0, 30)));
      #1;
      n_total++;
      if ({a.tc, b.tc} !== {((m99_val == 99) && a.en), ((m23_val == 23) && b.en)})
        $display("FAIL rnd_tc cyc=%0d got=%b%b exp=%b%b", i, a.tc, b.tc,
                 ((m99_val == 99) && a.en), ((m23_val == 23) && b.en));
      else n_pass++;
      tick();
      n_total++;
      if ({a.cnt_tens, a.cnt_ones, a.load_err} !== {to_bcd(m99_val), m99_err})
        $display("FAIL rnd_a cyc=%0d got=%h%h err=%b exp=%h err=%b", i, a.cnt_tens, a.cnt_ones,
                 a.load_err, to_bcd(m99_val), m99_err);
      else n_pass++;
      n_total++;
      if ({b.cnt_tens, b.cnt_ones, b.load_err} !== {to_bcd(m23_val), m23_err})
        $display("FAIL rnd_b cyc=%0d got=%h%h err=%b exp=%h err=%b", i, b.cnt_tens, b.cnt_ones,
                 b.load_err, to_bcd(m23_val), m23_err);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    n_txn   = 0;
    rst     = 1'b0;
    test_reset();
    test_valid_load();
    test_invalid_load();
    test_reduced_limit();
    test_hold();
    test_terminal();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
